mem_a_skew: RTL and testbench

//  Operand-A staging buffer for the DIM x DIM systolic MAC array. Stores one DIM x DIM

---
 rtl/systolic_pkg.sv | 13 +
 rtl/skew_lane.sv | 82 ++++++++
 rtl/mem_a_skew.sv | 91 +++++++++
 tb/tb_mem_a_skew.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default dimensions for the systolic MAC array blocks.
package systolic_pkg;

  localparam int unsigned BITS_AB_DEF = 8;
  localparam int unsigned BITS_C_DEF  = 32;
  localparam int unsigned DIM_DEF     = 8;

  typedef logic signed [BITS_AB_DEF-1:0] a_elem_t;
  typedef a_elem_t [DIM_DEF-1:0] a_row_t;

  typedef enum logic {StIdle, StStream} skew_state_t;

endpackage

// File: rtl/skew_lane.sv
// One west-edge lane: a stored A row, a parallel-load column shifter and a LANE-deep delay chain.
module skew_lane #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8,
  parameter int unsigned LANE    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic                   load_i,
  input  logic                   run_i,
  input  logic [DIM*BITS_AB-1:0] row_i,
  output logic [BITS_AB-1:0]     lane_o
);

  typedef logic [BITS_AB-1:0] elem_t;

  elem_t [DIM-1:0] mem_q;
  elem_t [DIM-1:0] shift_q;
  elem_t           feed;

  // Element 0 leaves straight from storage on the load edge, so the shifter keeps the rest.
  assign feed = load_i ? mem_q[0] : shift_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      shift_q <= '0;
    end else begin
      if (we_i) begin
        mem_q <= row_i;
      end
      if (load_i) begin
        shift_q <= mem_q >> BITS_AB;
      end else if (run_i) begin
        shift_q <= shift_q >> BITS_AB;
      end
    end
  end

  if (LANE == 0) begin : g_direct
    elem_t out_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q <= '0;
      end else begin
        out_q <= (load_i || run_i) ? feed : '0;
      end
    end

    assign lane_o = out_q;
  end else begin : g_chain
    elem_t [LANE-1:0] dly_q, dly_d;
    elem_t            out_q, out_d;

    always_comb begin
      dly_d = dly_q;
      out_d = '0;
      if (load_i || run_i) begin
        out_d = load_i ? '0 : dly_q[LANE-1];
        for (int unsigned k = 1; k < LANE; k++) begin
          dly_d[k] = load_i ? '0 : dly_q[k-1];
        end
        dly_d[0] = feed;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dly_q <= '0;
        out_q <= '0;
      end else begin
        dly_q <= dly_d;
        out_q <= out_d;
      end
    end

    assign lane_o = out_q;
  end

endmodule

// File: rtl/mem_a_skew.sv
// Operand-A staging buffer: stores a DIM x DIM tile and streams it diagonally skewed.
module mem_a_skew
  import systolic_pkg::*;
#(
  parameter int unsigned BITS_AB    = BITS_AB_DEF,
  parameter int unsigned DIM        = DIM_DEF,
  localparam int unsigned ROWBITS   = $clog2(DIM),
  localparam int unsigned STEPBITS  = $clog2(2*DIM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ROWBITS-1:0]     a_row,
  input  logic [DIM*BITS_AB-1:0] Ain,
  input  logic                   start,
  output logic [DIM*BITS_AB-1:0] Aout,
  output logic                   valid,
  output logic [STEPBITS-1:0]    step,
  output logic                   busy,
  output logic                   done
);

  localparam logic [STEPBITS-1:0] LastStep = STEPBITS'(2*DIM-2);

  skew_state_t         state_q;
  logic [STEPBITS-1:0] step_q;
  logic                done_q;
  logic                idle;
  logic                load;
  logic                run;

  // A write in the same cycle as start wins; start is dropped.
  assign idle = (state_q == StIdle);
  assign load = idle && start && !wr_en;
  assign run  = (state_q == StStream) && (step_q != LastStep);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (load) begin
            state_q <= StStream;
            step_q  <= '0;
            done_q  <= 1'b0;
          end
        end
        StStream: begin
          if (step_q == LastStep) begin
            state_q <= StIdle;
            step_q  <= '0;
            done_q  <= 1'b0;
          end else begin
            step_q <= step_q + 1'b1;
            done_q <= ((step_q + 1'b1) == LastStep);
          end
        end
        default: begin
          state_q <= StIdle;
          step_q  <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid = (state_q == StStream);
  assign busy  = (state_q == StStream);
  assign step  = step_q;
  assign done  = done_q;

  for (genvar r = 0; r < DIM; r++) begin : g_lane
    skew_lane #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .LANE    (r)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .we_i   (wr_en && idle && (a_row == ROWBITS'(r))),
      .load_i (load),
      .run_i  (run),
      .row_i  (Ain),
      .lane_o (Aout[r*BITS_AB +: BITS_AB])
    );
  end

endmodule

// File: tb/tb_mem_a_skew.sv
// Bench for mem_a_skew: tile/stream model checked every cycle plus hand-computed spot values.
module tb_mem_a_skew;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int NL      = DIM * BITS_AB;
  localparam int LAST    = 2 * DIM - 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [2:0]    a_row = '0;
  logic [NL-1:0] Ain = '0;
  logic          start = 1'b0;
  logic [NL-1:0] Aout;
  logic          valid;
  logic [3:0]    step;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  mem_a_skew #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .a_row (a_row),
    .Ain   (Ain),
    .start (start),
    .Aout  (Aout),
    .valid (valid),
    .step  (step),
    .busy  (busy),
    .done  (done)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lane(input int r);
    return int'($signed(Aout[r*BITS_AB +: BITS_AB]));
  endfunction

  // Model: the stored tile plus "streaming, at step i"; lane r shows tile[r][i-r] in its window.
  int tile [DIM][DIM];
  bit m_busy = 1'b0;
  int m_step = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) tile[r][c] <= 0;
      m_busy <= 1'b0;
      m_step <= 0;
    end else if (m_busy) begin
      if (m_step == LAST) begin
        m_busy <= 1'b0;
        m_step <= 0;
      end else begin
        m_step <= m_step + 1;
      end
    end else if (wr_en) begin
      for (int c = 0; c < DIM; c++)
        tile[a_row][c] <= int'($signed(Ain[c*BITS_AB +: BITS_AB]));
    end else if (start) begin
      m_busy <= 1'b1;
      m_step <= 0;
    end
  end

  function automatic int exp_lane(input int r);
    int idx;
    idx = m_step - r;
    if (m_busy && idx >= 0 && idx < DIM) return tile[r][idx];
    return 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", int'(valid), int'(m_busy));
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_busy && m_step == LAST));
      check("step", int'(step), m_busy ? m_step : 0);
      for (int r = 0; r < DIM; r++)
        check($sformatf("aout_lane%0d", r), lane(r), exp_lane(r));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic write_row(input int r, input logic [NL-1:0] d);
    wr_en = 1'b1;
    a_row = 3'(r);
    Ain   = d;
    cyc();
    wr_en = 1'b0;
  endtask

  function automatic logic [NL-1:0] pat_row(input int r);
    logic [NL-1:0] v;
    for (int c = 0; c < DIM; c++) v[c*BITS_AB +: BITS_AB] = 8'(r * 8 + c + 1);
    return v;
  endfunction

  task automatic load_pattern();
    for (int r = 0; r < DIM; r++) write_row(r, pat_row(r));
  endtask

  task automatic wait_step(input int s);
    int n;
    n = 0;
    while (!(valid && int'(step) == s) && n < 40) begin
      cyc();
      n++;
    end
    if (n >= 40) check($sformatf("wait_step%0d_timeout", s), n, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (valid && n < 40) begin
      cyc();
      n++;
    end
    if (n >= 40) check("wait_idle_timeout", n, 0);
  endtask

  logic [NL-1:0] all_7f;
  logic [NL-1:0] all_80;
  int            vrec [40];
  int            srec [40];

  initial begin
    int  n;
    int  nv;
    int  z;
    int  gap;
    bit  prev_done;
    bit  launched;

    all_7f = {DIM{8'h7f}};
    all_80 = {DIM{8'h80}};

    // Reset held for two edges
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_aout_nonzero", int'(|Aout), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_step", int'(step), 0);
    chk_en = 1'b1;

    // Empty tile streams 15 zero steps
    pulse_start();
    check("empty_first_valid", int'(valid), 1);
    check("empty_first_step", int'(step), 0);
    n = 0;
    while (valid && n < 40) begin
      n++;
      cyc();
    end
    check("empty_stream_len", n, 15);

    // A[r][c] = r*8+c+1
    load_pattern();
    pulse_start();
    check("pat_s0_lane0", lane(0), 1);
    check("pat_s0_lane1", lane(1), 0);
    check("pat_s0_lane7", lane(7), 0);
    wait_step(7);
    check("pat_s7_lane0", lane(0), 8);
    check("pat_s7_lane7", lane(7), 57);
    wait_step(14);
    check("pat_s14_lane7", lane(7), 64);
    check("pat_s14_lane0", lane(0), 0);
    check("pat_s14_done", int'(done), 1);
    cyc();
    check("pat_after_valid", int'(valid), 0);
    check("pat_after_step", int'(step), 0);
    check("pat_after_aout_nonzero", int'(|Aout), 0);

    // Signed extreme on row 3
    write_row(3, all_80);
    pulse_start();
    wait_step(3);
    check("neg_s3_lane3", lane(3), -128);
    wait_step(10);
    check("neg_s10_lane3", lane(3), -128);
    wait_step(11);
    check("neg_s11_lane3", lane(3), 0);
    wait_idle();

    // Write while streaming is dropped
    pulse_start();
    wait_step(5);
    write_row(2, all_7f);
    check("busywr_s6_lane2", lane(2), 21);
    wait_idle();
    pulse_start();
    wait_step(2);
    check("restream_s2_lane2", lane(2), 17);
    wait_step(9);
    check("restream_s9_lane2", lane(2), 24);
    wait_idle();

    // Same-cycle start+write in idle: write lands, start dropped
    wr_en = 1'b1;
    a_row = 3'd2;
    Ain   = all_7f;
    start = 1'b1;
    cyc();
    wr_en = 1'b0;
    start = 1'b0;
    check("wrstart_valid0", int'(valid), 0);
    check("wrstart_busy0", int'(busy), 0);
    cyc();
    check("wrstart_valid1", int'(valid), 0);
    pulse_start();
    wait_step(2);
    check("wrstart_s2_lane2", lane(2), 127);

    // Reset mid-stream at step 6
    wait_step(6);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_valid", int'(valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    pulse_start();
    wait_step(7);
    check("abort_s7_lane0", lane(0), 0);
    check("abort_s7_lane3", lane(3), 0);
    wait_idle();

    // Back-to-back: second start in the idle cycle right after done
    load_pattern();
    pulse_start();
    prev_done = 1'b0;
    launched  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      vrec[k] = int'(valid);
      srec[k] = int'(step);
      start = prev_done && !valid && !launched;
      if (start) launched = 1'b1;
      prev_done = done;
      cyc();
    end
    start = 1'b0;
    nv = 0;
    z  = -1;
    for (int k = 0; k < 40; k++) begin
      nv += vrec[k];
      if (z < 0 && vrec[k] == 0) z = k;
    end
    gap = 0;
    if (z >= 0) begin
      for (int k = z; k < 40 && vrec[k] == 0; k++) gap++;
    end
    check("b2b_valid_count", nv, 30);
    check("b2b_first_gap_at", z, 15);
    check("b2b_gap_len", gap, 1);
    check("b2b_restart_step", srec[16], 0);
    check("b2b_second_end", vrec[31], 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
